// File: rtl/alu_req_resp.sv
// Request/response front-end for the 8-bit ALU: one registered compute stage
// feeding an in-order response FIFO with valid/ready on both sides.
module alu_req_resp #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_a,
  input  logic [7:0]    req_b,
  input  logic [2:0]    req_op,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [7:0]    resp_result,
  output logic          resp_zero,
  output logic          resp_carry,
  output logic          resp_err,
  output logic [CW-1:0] resp_count,
  output logic [7:0]    ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;
  } resp_t;

  logic          stage_valid_q;
  logic [7:0]    stage_a_q, stage_b_q;
  logic [2:0]    stage_op_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    ops_done_q;
  resp_t         mem_q [DEPTH];
  resp_t         stage_resp;
  resp_t         head;
  logic [CW:0]   occupancy;
  logic          accept, push, pop;

  // Stage and FIFO together never exceed DEPTH, so a stage push always has room.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, stage_valid_q};
  assign req_ready = occupancy < DEPTH_W;
  assign accept    = req_valid && req_ready;
  assign push      = stage_valid_q;
  assign pop       = resp_valid && resp_ready;

  always_comb begin
    stage_resp = '0;
    case (stage_op_q)
      OP_ADD:  {stage_resp.carry, stage_resp.result} = {1'b0, stage_a_q} + {1'b0, stage_b_q};
      OP_SUB: begin
        stage_resp.result = stage_a_q - stage_b_q;
        stage_resp.carry  = stage_a_q < stage_b_q;
      end
      OP_AND:  stage_resp.result = stage_a_q & stage_b_q;
      OP_OR:   stage_resp.result = stage_a_q | stage_b_q;
      OP_XOR:  stage_resp.result = stage_a_q ^ stage_b_q;
      OP_NOR:  stage_resp.result = ~(stage_a_q | stage_b_q);
      default: stage_resp.err = 1'b1;
    endcase
    stage_resp.zero = (stage_resp.result == 8'h00);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_a_q     <= '0;
      stage_b_q     <= '0;
      stage_op_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ops_done_q    <= '0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_a_q  <= req_a;
        stage_b_q  <= req_b;
        stage_op_q <= req_op;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) ops_done_q <= ops_done_q + 8'd1;
    end
  end

  // NOTE: storage is deliberately left unreset; an empty FIFO masks the head
  // to zero, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stage_resp;
  end

  assign resp_valid  = (count_q != '0);
  assign head        = resp_valid ? mem_q[rd_ptr_q] : '0;
  assign resp_result = head.result;
  assign resp_zero   = head.zero;
  assign resp_carry  = head.carry;
  assign resp_err    = head.err;
  assign resp_count  = count_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_req_resp.sv
// Directed bench for alu_req_resp: latency, ALU results, flags, full/backpressure
// behaviour and asynchronous reset, all against hand-computed expectations.
module tb_alu_req_resp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [2:0] req_op = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_result;
  logic       resp_zero, resp_carry, resp_err;
  logic [2:0] resp_count;
  logic [7:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_req_resp #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_carry(resp_carry), .resp_err(resp_err),
    .resp_count(resp_count), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request at a falling edge; it is accepted at the next rising edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    check("req_ready_before_send", req_ready, 1);
    @(negedge clk);
  endtask

  // Waits (bounded) for a head entry, checks it, then lets the pop happen.
  task automatic get_resp(input string tag, input logic [7:0] r, input logic z,
                          input logic c, input logic e);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"},  resp_valid,  1);
    check({tag, ".result"}, resp_result, r);
    check({tag, ".zero"},   resp_zero,   z);
    check({tag, ".carry"},  resp_carry,  c);
    check({tag, ".err"},    resp_err,    e);
    @(negedge clk);
  endtask

  initial begin
    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst.resp_valid",  resp_valid,  0);
    check("rst.resp_result", resp_result, 0);
    check("rst.resp_zero",   resp_zero,   0);
    check("rst.resp_count",  resp_count,  0);
    check("rst.ops_done",    ops_done,    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.req_ready", req_ready, 1);

    // ADD 0C+05 with exact two-cycle latency
    resp_ready = 1'b1;
    send(8'h0C, 8'h05, 3'b000);
    req_valid = 1'b0;
    check("add.latency_stage", resp_valid, 0);
    @(negedge clk);
    check("add.latency_valid", resp_valid, 1);
    check("add.count", resp_count, 1);
    get_resp("add", 8'h11, 0, 0, 0);
    check("add.ops_done", ops_done, 1);
    check("add.drained", resp_valid, 0);

    // SUB with and without borrow, back-to-back
    send(8'd12, 8'd5, 3'b001);
    send(8'd5, 8'd12, 3'b001);
    req_valid = 1'b0;
    get_resp("sub1", 8'h07, 0, 0, 0);
    check("sub2.back_to_back", resp_valid, 1);
    get_resp("sub2", 8'hF9, 0, 1, 0);
    check("sub.ops_done", ops_done, 3);

    // Bitwise operations, buffered then drained
    resp_ready = 1'b0;
    send(8'hCC, 8'hAA, 3'b010);
    send(8'hCC, 8'hAA, 3'b011);
    send(8'hCC, 8'hAA, 3'b100);
    send(8'hCC, 8'hAA, 3'b101);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    get_resp("and", 8'h88, 0, 0, 0);
    get_resp("or",  8'hEE, 0, 0, 0);
    get_resp("xor", 8'h66, 0, 0, 0);
    get_resp("nor", 8'h11, 0, 0, 0);
    check("logic.ops_done", ops_done, 7);

    // ADD overflow to zero, then both illegal opcodes
    resp_ready = 1'b0;
    send(8'hFF, 8'h01, 3'b000);
    send(8'h00, 8'h00, 3'b110);
    send(8'hFF, 8'h0F, 3'b111);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    get_resp("add_wrap", 8'h00, 1, 1, 0);
    get_resp("ill110",   8'h00, 1, 0, 1);
    get_resp("ill111",   8'h00, 1, 0, 1);
    check("flags.ops_done", ops_done, 10);

    // Fill under backpressure: exactly four accepts
    resp_ready = 1'b0;
    send(8'd1, 8'd0, 3'b000);
    send(8'd2, 8'd0, 3'b000);
    send(8'd3, 8'd0, 3'b000);
    send(8'd4, 8'd0, 3'b000);
    req_a = 8'd99;
    check("full.ready_low", req_ready, 0);
    @(negedge clk);
    check("full.ready_still_low", req_ready, 0);
    check("full.count", resp_count, 4);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    check("full.head", resp_result, 1);
    @(negedge clk);
    resp_ready = 1'b0;
    check("full.ready_after_pop", req_ready, 1);
    check("full.count_after_pop", resp_count, 3);
    check("full.next_head", resp_result, 2);
    resp_ready = 1'b1;
    get_resp("full2", 8'd2, 0, 0, 0);
    get_resp("full3", 8'd3, 0, 0, 0);
    get_resp("full4", 8'd4, 0, 0, 0);
    check("full.ops_done", ops_done, 14);
    check("full.drained", resp_count, 0);

    // Reset in the middle of a cycle with three buffered entries
    resp_ready = 1'b0;
    send(8'd7, 8'd1, 3'b000);
    send(8'd7, 8'd2, 3'b000);
    send(8'd7, 8'd3, 3'b000);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid.count_before", resp_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid.resp_valid", resp_valid, 0);
    check("mid.resp_count", resp_count, 0);
    check("mid.ops_done",   ops_done,   0);
    check("mid.resp_result", resp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.ready_after", req_ready, 1);
    resp_ready = 1'b1;
    send(8'h00, 8'h00, 3'b000);
    req_valid = 1'b0;
    check("mid.full_latency", resp_valid, 0);
    get_resp("post_rst", 8'h00, 1, 0, 0);
    check("post_rst.ops_done", ops_done, 1);
    check("post_rst.count", resp_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
